seg7_scan_display: RTL and testbench

- Parametrised, time-multiplexed 7-segment driver for the board's common-anode displays.
- Shows a hex value of DIGITS nibbles, with:
  - per-digit decimal point and blink,
  - leading-zero blanking,
  - inter-digit ghost guard,
  - frame-synchronous value update, so a digit never tears mid-frame.
- Sits between the CPU debug/register-select logic and the board pins.
- Runs entirely in the system clock domain; a single-cycle tick enable replaces any derived clock.

---
 rtl/seg7_pkg.sv | 15 +
 rtl/seg7_scan_display_if.sv | 24 ++
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_scan_display.sv | 139 +++++++++++++
 tb/tb_seg7_scan_display.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: blank pattern and the
// active-low hex glyph table (bit7 = dp, held off here).
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Index = nibble value; bits 6..0 = g..a, low lights the segment.
  localparam logic [7:0] SEG_HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/seg7_scan_display_if.sv
// Load bus between the CPU debug/register-select logic and the scan driver.
interface seg7_scan_display_if #(
  parameter int DIGITS = 4
);
  // Handshake: load is a one-cycle valid strobe with no ready; the driver
  // always accepts it. pending reports a captured value waiting for the
  // frame boundary, and frame_done marks that boundary for one cycle.
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_mask;
  logic [DIGITS-1:0]     blink_mask;
  logic                  pending;
  logic                  frame_done;

  modport master (
    output load, value, dp_mask, blink_mask,
    input  pending, frame_done
  );

  modport slave (
    input  load, value, dp_mask, blink_mask,
    output pending, frame_done
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low 7-segment pattern (bits 6..0 = g..a).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nibble][6:0];

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed common-anode 7-segment driver with ghost guard, blink,
// leading-zero blanking and frame-synchronous value update.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int CLK_DIV   = 10000,
  parameter int GUARD     = 16,
  parameter int BLINK_DIV = 5000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                lz_blank_en,
  seg7_scan_display_if.slave  bus,
  output logic [DIGITS-1:0]   digit_sel,
  output logic [7:0]          seg_display
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int IDX_W = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam int BLK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GUARD_C  = DIV_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    scan_idx;
  logic [BLK_W-1:0]    blink_cnt;
  logic                blink_phase;   // 1 = blinking digits dark

  logic [4*DIGITS-1:0] value_sh, value_pd;
  logic [DIGITS-1:0]   dp_sh, dp_pd;
  logic [DIGITS-1:0]   blink_sh, blink_pd;
  logic                pending_q;

  logic                slot_end;
  logic                frame_end;
  logic [IDX_W-1:0]    hi_idx;
  logic [3:0]          cur_nib;
  logic [6:0]          cur_seg;
  logic                cur_blank;

  assign slot_end  = enable && (div_cnt == DIV_LAST);
  assign frame_end = slot_end && (scan_idx == IDX_LAST);

  assign bus.frame_done = frame_end;
  assign bus.pending    = pending_q;

  // Slot timing: counters idle at zero while disabled so a re-enable always
  // restarts at digit 0 with a full guard interval.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      scan_idx    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!enable) begin
      div_cnt     <= '0;
      scan_idx    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + DIV_W'(1);
      if (slot_end) begin
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
        if (blink_cnt == BLK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLK_W'(1);
        end
      end
    end
  end

  // Shadow only changes at a frame boundary (or while dark), so a digit
  // never shows a mix of old and new values within one frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_sh  <= '0;
      dp_sh     <= '0;
      blink_sh  <= '0;
      value_pd  <= '0;
      dp_pd     <= '0;
      blink_pd  <= '0;
      pending_q <= 1'b0;
    end else if (!enable || frame_end) begin
      if (bus.load) begin
        value_sh <= bus.value;
        dp_sh    <= bus.dp_mask;
        blink_sh <= bus.blink_mask;
      end else if (pending_q) begin
        value_sh <= value_pd;
        dp_sh    <= dp_pd;
        blink_sh <= blink_pd;
      end
      pending_q <= 1'b0;
    end else if (bus.load) begin
      value_pd  <= bus.value;
      dp_pd     <= bus.dp_mask;
      blink_pd  <= bus.blink_mask;
      pending_q <= 1'b1;
    end
  end

  // Highest nonzero nibble; stays 0 for an all-zero value so digit 0 shows.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (value_sh[4*i +: 4] != 4'h0) hi_idx = IDX_W'(i);
    end
  end

  assign cur_nib   = value_sh[{scan_idx, 2'b00} +: 4];
  assign cur_blank = (blink_sh[scan_idx] && blink_phase) ||
                     (lz_blank_en && (scan_idx > hi_idx) && !dp_sh[scan_idx]);

  seg7_decode u_decode (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_sel   <= '1;
      seg_display <= SEG_BLANK;
    end else if (!enable || (div_cnt < GUARD_C)) begin
      digit_sel   <= '1;
      seg_display <= SEG_BLANK;
    end else begin
      digit_sel   <= ~(DIGITS'(1) << scan_idx);
      seg_display <= cur_blank ? SEG_BLANK : {~dp_sh[scan_idx], cur_seg};
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: directed scenarios plus random traffic, all
// checked cycle by cycle against a time-based reference model.
module tb_seg7_scan_display;

  localparam int DIGITS    = 4;
  localparam int CLK_DIV   = 8;
  localparam int GUARD     = 2;
  localparam int BLINK_DIV = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              lz_blank_en;
  logic [DIGITS-1:0] digit_sel;
  logic [7:0]        seg_display;

  seg7_scan_display_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_display #(
    .DIGITS    (DIGITS),
    .CLK_DIV   (CLK_DIV),
    .GUARD     (GUARD),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .lz_blank_en (lz_blank_en),
    .bus         (bus),
    .digit_sel   (digit_sel),
    .seg_display (seg_display)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: t = enabled cycles since reset or enable low.
  int                t;
  logic [15:0]       m_val, p_val;
  logic [DIGITS-1:0] m_dp, m_bl, p_dp, p_bl;
  bit                m_pending;
  bit                fd_obs;

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [7:0] model_seg(input int d, input bit dark_phase);
    int hi = 0;
    for (int i = 0; i < DIGITS; i++) if (m_val[4*i +: 4] != 4'h0) hi = i;
    if (m_bl[d] && dark_phase) return 8'hFF;
    if (lz_blank_en && d > hi && !m_dp[d]) return 8'hFF;
    return glyph(m_val[4*d +: 4]) & (m_dp[d] ? 8'h7F : 8'hFF);
  endfunction

  function automatic bit model_fd_next();
    return (t % CLK_DIV == CLK_DIV - 1) && ((t / CLK_DIV) % DIGITS == DIGITS - 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; m_val = '0; p_val = '0; m_dp = '0; m_bl = '0;
    p_dp = '0; p_bl = '0; m_pending = 0;
  endtask

  // One clock: pre-edge checks, model update, post-edge output checks.
  task automatic step();
    int                off, slot, dig;
    bit                dark, fd;
    logic [DIGITS-1:0] e_sel;
    logic [7:0]        e_seg;
    #1;
    off  = t % CLK_DIV;
    slot = t / CLK_DIV;
    dig  = slot % DIGITS;
    dark = ((slot / BLINK_DIV) % 2) == 1;
    fd   = enable && (off == CLK_DIV - 1) && (dig == DIGITS - 1);
    check("frame_done", bus.frame_done, fd);
    check("pending", bus.pending, m_pending);
    fd_obs = bus.frame_done;
    if (!enable || off < GUARD) begin
      e_sel = '1; e_seg = 8'hFF;
    end else begin
      e_sel = ~(DIGITS'(1) << dig); e_seg = model_seg(dig, dark);
    end
    if (!enable || fd) begin
      if (bus.load) begin
        m_val = bus.value; m_dp = bus.dp_mask; m_bl = bus.blink_mask;
      end else if (m_pending) begin
        m_val = p_val; m_dp = p_dp; m_bl = p_bl;
      end
      m_pending = 0;
    end else if (bus.load) begin
      p_val = bus.value; p_dp = bus.dp_mask; p_bl = bus.blink_mask; m_pending = 1;
    end
    t = enable ? t + 1 : 0;
    @(posedge clk);
    @(negedge clk);
    check("digit_sel", digit_sel, e_sel);
    check("seg_display", seg_display, e_seg);
    bus.load = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_fd(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = fd_obs;
    end
    check("frame_done_reached", seen, 1);
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [DIGITS-1:0] dp,
                            input logic [DIGITS-1:0] bl);
    bus.value = v; bus.dp_mask = dp; bus.blink_mask = bl; bus.load = 1'b1;
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("rst_digit_sel", digit_sel, {DIGITS{1'b1}});
    check("rst_seg", seg_display, 8'hFF);
    check("rst_pending", bus.pending, 0);
    check("rst_frame_done", bus.frame_done, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int  cnt;
    bit  seen;
    reset = 1'b1; enable = 1'b0; lz_blank_en = 1'b0;
    bus.load = 1'b0; bus.value = '0; bus.dp_mask = '0; bus.blink_mask = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_digit_sel", digit_sel, 4'b1111);
    check("reset_seg", seg_display, 8'hFF);
    check("reset_pending", bus.pending, 0);
    check("reset_frame_done", bus.frame_done, 0);
    reset = 1'b0;

    // Basic scan of 12AF after the first frame boundary.
    enable = 1'b1;
    drive_load(16'h12AF, 4'b0000, 4'b0000);
    step();
    check("t1_pending_set", bus.pending, 1);
    wait_fd(40);
    run(3);
    check("t1_digit0_seg", seg_display, 8'h8E);
    check("t1_digit0_sel", digit_sel, 4'b1110);
    run(29);

    // Last load before the boundary wins.
    run(5);
    drive_load(16'h0001, 4'b0000, 4'b0000);
    step();
    check("t2_pending_after_first", bus.pending, 1);
    run(3);
    drive_load(16'h0002, 4'b0000, 4'b0000);
    wait_fd(40);
    check("t2_pending_cleared", bus.pending, 0);
    run(3);
    check("t2_digit0_seg", seg_display, 8'hA4);
    run(29);

    // Leading-zero blanking, all-zero value, dp overriding blanking.
    lz_blank_en = 1'b1;
    drive_load(16'h0030, 4'b0000, 4'b0000);
    wait_fd(40);
    run(32);
    drive_load(16'h0000, 4'b0000, 4'b0000);
    wait_fd(40);
    run(32);
    drive_load(16'h0000, 4'b0100, 4'b0000);
    wait_fd(40);
    run(19);
    check("t3_dp_digit2_seg", seg_display, 8'h40);
    check("t3_dp_digit2_sel", digit_sel, 4'b1011);
    run(13);

    // Blink on digit 0 across several half-periods.
    lz_blank_en = 1'b0;
    drive_load(16'h12AF, 4'b0000, 4'b0001);
    wait_fd(40);
    run(128);

    // Load coinciding with the frame boundary goes straight to the shadow.
    cnt = 0;
    while (!model_fd_next() && cnt < 40) begin step(); cnt++; end
    drive_load(16'h5A3C, 4'b0000, 4'b0000);
    step();
    check("t5_fd_on_load", fd_obs, 1);
    check("t5_pending_zero", bus.pending, 0);
    run(3);
    check("t5_digit0_seg", seg_display, 8'hC6);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      enable = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 19) == 0) lz_blank_en = ~lz_blank_en;
      if ($urandom_range(0, 9) == 0)
        drive_load(16'($urandom), 4'($urandom), 4'($urandom));
      step();
    end

    // Async reset mid-slot with a pending value, then enable low, then restart.
    enable = 1'b1;
    run(10);
    drive_load(16'h7777, 4'b0000, 4'b0000);
    step();
    async_reset();
    enable = 1'b0;
    run(20);
    enable = 1'b1;
    cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      cnt++;
      seen = fd_obs;
    end
    check("t7_first_fd_cycle", cnt, 32);
    run(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
